// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int XLEN         = 32;
  localparam int FETCH_QDEPTH = 2;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Clears the byte-offset bits so the PC can never become misaligned.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetch entries; flush beats push, head holds its last value when empty.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t e0_q;
  fetch_entry_t e1_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         do_push;
  logic         do_pop;
  logic         e0_load_new;
  logic         e0_load_e1;
  logic         e1_load_new;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q < 2'(FETCH_QDEPTH)) || do_pop);

  // Entry 0 is always the head; a pop from a full queue shifts entry 1 forward.
  assign e0_load_new = do_push && ((count_q == 2'd0) || ((count_q == 2'd1) && do_pop));
  assign e0_load_e1  = do_pop && (count_q == 2'd2);
  assign e1_load_new = do_push && (((count_q == 2'd1) && !do_pop) || (count_q == 2'd2));

  // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 2'd1;
    else if (do_pop && !do_push) count_d = count_q - 2'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      e0_q    <= '0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
      if (e0_load_new)     e0_q <= push_data;
      else if (e0_load_e1) e0_q <= e1_q;
    end
  end

  // NOTE: entry 1 has no reset; it is never visible before being written, so only the head needs one.
  always_ff @(posedge clk) begin
    if (!flush && e1_load_new) e1_q <= push_data;
  end

  assign count = count_q;
  assign head  = e0_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC, imem read port, redirect handling and 2-entry fetch queue.
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] perf_fetched,
  output logic [XLEN-1:0] perf_stall
);

  logic [XLEN-1:0] pc_q;
  logic [1:0]      count;
  fetch_entry_t    head;
  fetch_entry_t    new_entry;
  logic            pop;
  logic            space;
  logic            push;
  logic            stall;

  assign pop   = out_valid && out_ready;
  assign space = (count < 2'(FETCH_QDEPTH)) || pop;
  assign push  = !redirect_valid && space;
  assign stall = !redirect_valid && !space;

  assign new_entry = '{pc: pc_q, instr: imem_instr};

  always_ff @(posedge clk) begin
    if (rst)                 pc_q <= RESET_PC;
    else if (redirect_valid) pc_q <= align_pc(redirect_pc);
    else if (space)          pc_q <= pc_q + 32'd4;
  end

  // A pop coinciding with a redirect is still consumed by decode; the flush drops the rest.
  fetch_queue u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (new_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

  assign imem_addr = pc_q;
  assign out_valid = (count != 2'd0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] fetched_q;
  logic [XLEN-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      if (push)  fetched_q <= fetched_q + 32'd1;
      if (stall) stall_q   <= stall_q + 32'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
`else
  logic unused_stall;
  assign unused_stall = stall;
  assign perf_fetched = '0;
  assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: cycle-by-cycle vector table plus an in-order delivery scoreboard.
module tb_instr_fetch;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ei;
    logic [31:0] ea;
    logic [31:0] epf;
    logic [31:0] eps;
  } vec_t;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;

  logic [31:0] mem [256];
  vec_t        vecs [$];
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[8'(imem_addr >> 2)];

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy,
                     input logic ev, input logic [31:0] epc, input logic [31:0] ei,
                     input logic [31:0] ea, input logic [31:0] epf, input logic [31:0] eps);
    vec_t v;
    v = '{rst: r, rv: rv, rpc: rpc, rdy: rdy, ev: ev, epc: epc, ei: ei, ea: ea, epf: epf, eps: eps};
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          pops;

    for (int i = 0; i < 256; i++) mem[i] = 32'hC000_0000 + 32'(i);
    mem[0] = 32'h0010_0093;
    mem[1] = 32'h0020_0113;
    mem[2] = 32'h0020_81B3;
    mem[3] = 32'h0000_0013;

    // Columns: rst rv rpc rdy | valid pc instr addr perf_fetched perf_stall (outputs during that cycle)
    // Streaming after reset
    add(0, 0, 32'h0,        1, 0, 32'h0,        32'h0,         32'h0,        0, 0);
    add(0, 0, 32'h0,        1, 1, 32'h0,        32'h0010_0093, 32'h4,        1, 0);
    add(0, 0, 32'h0,        1, 1, 32'h4,        32'h0020_0113, 32'h8,        2, 0);
    add(0, 0, 32'h0,        1, 1, 32'h8,        32'h0020_81B3, 32'hC,        3, 0);
    add(0, 0, 32'h0,        1, 1, 32'hC,        32'h0000_0013, 32'h10,       4, 0);
    add(1, 0, 32'h0,        1, 1, 32'h10,       32'hC000_0004, 32'h14,       5, 0);
    // Back-pressure: out_ready low for 5 cycles, then drain
    add(0, 0, 32'h0,        1, 0, 32'h0,        32'h0,         32'h0,        0, 0);
    add(0, 0, 32'h0,        0, 1, 32'h0,        32'h0010_0093, 32'h4,        1, 0);
    add(0, 0, 32'h0,        0, 1, 32'h0,        32'h0010_0093, 32'h8,        2, 0);
    add(0, 0, 32'h0,        0, 1, 32'h0,        32'h0010_0093, 32'h8,        2, 1);
    add(0, 0, 32'h0,        0, 1, 32'h0,        32'h0010_0093, 32'h8,        2, 2);
    add(0, 0, 32'h0,        0, 1, 32'h0,        32'h0010_0093, 32'h8,        2, 3);
    add(0, 0, 32'h0,        1, 1, 32'h0,        32'h0010_0093, 32'h8,        2, 4);
    add(0, 0, 32'h0,        1, 1, 32'h4,        32'h0020_0113, 32'hC,        3, 4);
    add(0, 0, 32'h0,        1, 1, 32'h8,        32'h0020_81B3, 32'h10,       4, 4);
    // Reset with the queue full
    add(1, 0, 32'h0,        0, 1, 32'hC,        32'h0000_0013, 32'h14,       5, 4);
    add(0, 0, 32'h0,        1, 0, 32'h0,        32'h0,         32'h0,        0, 0);
    add(0, 0, 32'h0,        1, 1, 32'h0,        32'h0010_0093, 32'h4,        1, 0);
    // Queue fills with PCs 4 and 8, then redirect to a misaligned target
    add(0, 0, 32'h0,        0, 1, 32'h4,        32'h0020_0113, 32'h8,        2, 0);
    add(0, 1, 32'h102,      0, 1, 32'h4,        32'h0020_0113, 32'hC,        3, 0);
    add(0, 0, 32'h0,        1, 0, 32'h4,        32'h0020_0113, 32'h100,      3, 0);
    add(0, 0, 32'h0,        0, 1, 32'h100,      32'hC000_0040, 32'h104,      4, 0);
    // Redirect together with a pop; target near the top of the address space
    add(0, 1, 32'hFFFF_FFFE, 1, 1, 32'h100,    32'hC000_0040, 32'h108,      5, 0);
    add(0, 0, 32'h0,        1, 0, 32'h100,      32'hC000_0040, 32'hFFFF_FFFC, 5, 0);
    add(0, 0, 32'h0,        1, 1, 32'hFFFF_FFFC, 32'hC000_00FF, 32'h0,       6, 0);
    add(0, 0, 32'h0,        1, 1, 32'h0,        32'h0010_0093, 32'h4,        7, 0);
    // Back-to-back redirects: last one wins
    add(0, 1, 32'h40,       1, 1, 32'h4,        32'h0020_0113, 32'h8,        8, 0);
    add(0, 1, 32'h80,       1, 0, 32'h4,        32'h0020_0113, 32'h40,       8, 0);
    add(0, 0, 32'h0,        1, 0, 32'h4,        32'h0020_0113, 32'h80,       8, 0);
    add(0, 0, 32'h0,        1, 1, 32'h80,       32'hC000_0020, 32'h84,       9, 0);

    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset out_pc", out_pc, 32'h0);
    check("reset out_instr", out_instr, 32'h0);
    check("reset imem_addr", imem_addr, 32'h0);
    check("reset perf_fetched", perf_fetched, 32'h0);
    check("reset perf_stall", perf_stall, 32'h0);

    foreach (vecs[i]) begin
      rst            = vecs[i].rst;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      out_ready      = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("c%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      check($sformatf("c%0d out_pc", i), out_pc, vecs[i].epc);
      check($sformatf("c%0d out_instr", i), out_instr, vecs[i].ei);
      check($sformatf("c%0d imem_addr", i), imem_addr, vecs[i].ea);
      check($sformatf("c%0d perf_fetched", i), perf_fetched, PERF ? vecs[i].epf : 32'h0);
      check($sformatf("c%0d perf_stall", i), perf_stall, PERF ? vecs[i].eps : 32'h0);
      @(posedge clk);
      #1;
    end

    // Intermittent out_ready: every accepted instruction must be the next sequential PC.
    exp_pc = 32'h84;
    pops   = 0;
    for (int i = 0; i < 40; i++) begin
      rst            = 1'b0;
      redirect_valid = 1'b0;
      out_ready      = (i % 3) != 0;
      @(negedge clk);
      if (out_valid && out_ready) begin
        check($sformatf("seq%0d pc", i), out_pc, exp_pc);
        check($sformatf("seq%0d instr", i), out_instr, mem[8'(exp_pc >> 2)]);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      @(posedge clk);
      #1;
    end
    check("seq accepted count", 32'(pops), 32'd26);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the initiator side of the instruction memory read port. Holds the program counter, drives the word address to the combinational instruction memory, and captures each returned instruction with its PC into a 2-entry fetch queue. Presents fetched instructions to decode over a valid/ready handshake and accepts PC redirects from execute for branches and jumps.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- imem_addr  output  32  byte address to instruction memory; memory indexes addr[9:2]
- imem_instr  input  32  instruction word, combinational from imem_addr, same cycle
- redirect_valid  input  1  load new PC and flush this cycle
- redirect_pc  input  32  redirect target; bits [1:0] ignored
- out_valid  output  1  queue head valid
- out_ready  input  1  decode accepts head
- out_pc  output  32  PC of head instruction
- out_instr  output  32  head instruction word
- perf_fetched  output  32  instructions pushed (see Configuration)
- perf_stall  output  32  cycles fetch blocked by full queue (see Configuration)

## Operation
- Clock `clk`; reset `rst` is synchronous and active-high.
- imem_addr = pc, combinational; pc always word-aligned.
- pop = out_valid && out_ready.
- space = (count < 2) || pop.
- Per cycle, priority order:
  - rst: pc <= RESET_PC; count <= 0.
  - redirect_valid: pc <= {redirect_pc[31:2], 2'b00}; queue flushed (count <= 0); no push. A pop in the same cycle still counts as consumed by decode; the remaining entries are discarded.
  - else if space: push {pc, imem_instr}; pc <= pc + 4.
  - else: hold pc; stall cycle.
- Queue is FIFO, depth 2, state = count in {0,1,2}:
  - count 0: push only.
  - count 1: push and/or pop.
  - count 2: push only together with pop; count stays 2.
- pc + 4 wraps modulo 2^32. Memory wraps at 1 KiB through addr[9:2]; no special handling.
- out_pc/out_instr are valid only when out_valid = 1. When the queue is empty they hold the last head value, or 0 after reset.

## Timing
- Reset values: out_valid 0, out_pc 0, out_instr 0, imem_addr RESET_PC, perf counters 0.
- Latency: instruction at PC p fetched in cycle n appears at the queue head in cycle n+1 if the queue is empty.
- After rst deasserts at cycle 0: out_valid=1 at cycle 1 with PC RESET_PC. With out_ready held at 1, one instruction is delivered per cycle.
- Redirect in cycle n:
  - cycle n+1: out_valid=0; imem_addr=target.
  - cycle n+2: out_valid=1; out_pc=target.
  - Bubble is exactly 1 cycle.
- Redirect asserted on consecutive cycles: the last one wins; out_valid stays 0 until one cycle after the final redirect.
- out_ready low for k cycles with full queue: pc frozen for k cycles; no instruction is lost or duplicated.
- out_valid and the head data are stable while out_ready=0, unless redirect flushes.

## Configuration
- Macro FETCH_PERF_EN.
- Defined:
  - perf_fetched increments on every push.
  - perf_stall increments on every cycle with no redirect and no space.
  - Both counters are 32-bit, wrap, and clear on rst.
- Undefined: no counter registers; both perf outputs are tied to 32'h0.

## Structure
- Package fetch_pkg:
  - XLEN = 32
  - INSTR_NOP = 32'h0000_0013
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}
  - FETCH_QDEPTH = 2
- Sub-module fetch_queue:
  - Generic 2-entry FIFO of fetch_entry_t with push, pop, flush, count, and head.
  - Flush has priority over push.
- instr_fetch holds pc, the redirect/space logic, and the perf counters.

## Test plan
- Memory words 0..3 = 00100093, 00200113, 002081b3, 00000013; release rst; out_ready=1 -> cycles 1..4 deliver (pc,instr) = (0,00100093), (4,00200113), (8,002081b3), (C,00000013).
- out_ready=0 from cycle 1 for 5 cycles -> out_valid=1, head pc 0 stable; pc frozen at 8. Raise out_ready -> delivers PCs 0, 4, 8, C with no gap or duplicate. With FETCH_PERF_EN, perf_stall = 4.
- Redirect to 0x0000_0102 while the queue holds PCs 4 and 8 -> next cycle out_valid=0, imem_addr=0x100; following cycle out_pc=0x100.
- Redirect together with pop of PC 4 -> PC 4 counted as consumed; PC 8 discarded; next delivered pc = target.
- Redirect to 0xFFFF_FFFC -> delivers pc FFFFFFFC then 00000000; imem_addr wraps.
- Assert rst mid-stream with the queue full -> next cycle out_valid=0, imem_addr=RESET_PC, perf counters 0.
